// File: rtl/cache_pkg.sv
// Shared types and derived widths for the set-associative write-back cache.
//   - Default geometry constants (Def*) and the widths derived from them (IW, TW, AW).
//   - state_e : controller FSM states.
//   - line_t  : one cache line (valid, dirty, tag, data, LRU age).
// The line struct is sized from the Def* constants, so change the geometry here.
package cache_pkg;

    localparam int unsigned DefAddrW = 5;
    localparam int unsigned DefDataW = 3;
    localparam int unsigned DefSets  = 4;
    localparam int unsigned DefWays  = 4;

    localparam int unsigned IW = $clog2(DefSets);   // index bits
    localparam int unsigned TW = DefAddrW - IW;     // tag bits
    localparam int unsigned AW = $clog2(DefWays);   // age / way-select bits

    typedef enum logic [2:0] {
        StIdle,
        StLookup,
        StEvict,
        StFill,
        StResp
    } state_e;

    typedef struct packed {
        logic                valid;
        logic                dirty;
        logic [TW-1:0]       tag;
        logic [DefDataW-1:0] data;
        logic [AW-1:0]       age;
    } line_t;

endpackage

// File: rtl/cache_lru_ctrl.sv
// True-LRU helper for a single set (purely combinational).
//   valid_i   : per-way valid bits of the set
//   age_i     : per-way ages (0 = most recently used, WAYS-1 = least)
//   acc_way_i : way being accessed (hit way or freshly installed way)
//   age_o     : ages after touching acc_way_i
//   victim_o  : lowest-index invalid way, else the way whose age is WAYS-1
module cache_lru_ctrl #(
    parameter int unsigned WAYS = 4
) (
    input  logic [WAYS-1:0]                     valid_i,
    input  logic [WAYS-1:0][$clog2(WAYS)-1:0]   age_i,
    input  logic [$clog2(WAYS)-1:0]             acc_way_i,
    output logic [WAYS-1:0][$clog2(WAYS)-1:0]   age_o,
    output logic [$clog2(WAYS)-1:0]             victim_o
);

    localparam int unsigned AgeW = $clog2(WAYS);

    logic [AgeW-1:0] acc_age;
    logic            found;

    assign acc_age = age_i[acc_way_i];

    // Ways younger than the accessed one age by one; the accessed way becomes
    // youngest. This keeps the ages of a set a permutation of 0..WAYS-1.
    always_comb begin
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (AgeW'(w) == acc_way_i) begin
                age_o[w] = '0;
            end else if (age_i[w] < acc_age) begin
                age_o[w] = age_i[w] + 1'b1;
            end else begin
                age_o[w] = age_i[w];
            end
        end
    end

    always_comb begin
        victim_o = '0;
        found    = 1'b0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (!found && !valid_i[w]) begin
                victim_o = AgeW'(w);
                found    = 1'b1;
            end
        end
        if (!found) begin
            for (int unsigned w = 0; w < WAYS; w++) begin
                if (age_i[w] == AgeW'(WAYS - 1)) begin
                    victim_o = AgeW'(w);
                end
            end
        end
    end

endmodule

// File: rtl/cache_setassoc_wb.sv
// N-way set-associative, write-back, write-allocate cache with true-LRU replacement.
// CPU side : req_valid/req_ready handshake, address, wren, write -> read, read_valid, hit.
// Memory   : mem_req held until mem_ack; mem_we=1 write-back of a dirty victim,
//            mem_we=0 line fill (mem_rdata sampled in the mem_ack cycle).
// Optional : define CACHE_STATS_EN to add 16-bit hit_cnt, miss_cnt and evict_cnt outputs.
// Line geometry comes from cache_pkg; the parameters below default to it.
module cache_setassoc_wb
    import cache_pkg::*;
#(
    parameter int unsigned ADDR_W = DefAddrW,
    parameter int unsigned DATA_W = DefDataW,
    parameter int unsigned SETS   = DefSets,
    parameter int unsigned WAYS   = DefWays
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] address,
    input  logic              wren,
    input  logic [DATA_W-1:0] write,
    output logic [DATA_W-1:0] read,
    output logic              read_valid,
    output logic              hit,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
`ifdef CACHE_STATS_EN
    ,
    output logic [15:0]       hit_cnt,
    output logic [15:0]       miss_cnt,
    output logic [15:0]       evict_cnt
`endif
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic              wren_q;
    logic [DATA_W-1:0] wdata_q;
    logic [AW-1:0]     way_q;     // hit way, then victim/install way on a miss
    logic              hit_q;
    logic [DATA_W-1:0] rdata_q;
    line_t             lines_q [SETS][WAYS];

    logic [IW-1:0]               idx;
    logic [TW-1:0]               tag;
    logic [WAYS-1:0]             set_valid;
    logic [WAYS-1:0][AW-1:0]     set_age;
    logic [WAYS-1:0][AW-1:0]     age_new;
    logic                        hit_any;
    logic [AW-1:0]               hit_way;
    logic [AW-1:0]               victim_way;
    logic [AW-1:0]               acc_way;
    line_t                       victim_line;
    line_t                       cand_line;

    assign idx         = addr_q[IW-1:0];
    assign tag         = addr_q[ADDR_W-1:IW];
    assign victim_line = lines_q[idx][way_q];
    assign cand_line   = lines_q[idx][victim_way];
    assign acc_way     = (state_q == StLookup) ? hit_way : way_q;

    always_comb begin
        hit_any = 1'b0;
        hit_way = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            set_valid[w] = lines_q[idx][w].valid;
            set_age[w]   = lines_q[idx][w].age;
            if (lines_q[idx][w].valid && (lines_q[idx][w].tag == tag)) begin
                hit_any = 1'b1;
                hit_way = AW'(w);
            end
        end
    end

    cache_lru_ctrl #(
        .WAYS (WAYS)
    ) u_lru (
        .valid_i   (set_valid),
        .age_i     (set_age),
        .acc_way_i (acc_way),
        .age_o     (age_new),
        .victim_o  (victim_way)
    );

    // Next state and outputs.
    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        read_valid = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        unique case (state_q)
            StIdle: begin
                req_ready = 1'b1;
                if (req_valid) state_d = StLookup;
            end
            StLookup: begin
                if (hit_any) begin
                    state_d = StResp;
                end else if (cand_line.valid && cand_line.dirty) begin
                    state_d = StEvict;
                end else begin
                    state_d = StFill;
                end
            end
            StEvict: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {victim_line.tag, idx};
                mem_wdata = victim_line.data;
                if (mem_ack) state_d = StFill;
            end
            StFill: begin
                mem_req  = 1'b1;
                mem_addr = {tag, idx};
                if (mem_ack) state_d = StResp;
            end
            StResp: begin
                read_valid = 1'b1;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign hit  = read_valid & hit_q;
    assign read = rdata_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            addr_q  <= '0;
            wren_q  <= 1'b0;
            wdata_q <= '0;
            way_q   <= '0;
            hit_q   <= 1'b0;
            rdata_q <= '0;
            for (int unsigned s = 0; s < SETS; s++) begin
                for (int unsigned w = 0; w < WAYS; w++) begin
                    lines_q[s][w] <= '{valid: 1'b0, dirty: 1'b0, tag: '0, data: '0,
                                       age: AW'(w)};
                end
            end
        end else begin
            if ((state_q == StIdle) && req_valid) begin
                addr_q  <= address;
                wren_q  <= wren;
                wdata_q <= write;
            end
            if (state_q == StLookup) begin
                if (hit_any) begin
                    way_q <= hit_way;
                    hit_q <= 1'b1;
                    for (int unsigned w = 0; w < WAYS; w++) begin
                        lines_q[idx][w].age <= age_new[w];
                    end
                    if (wren_q) begin
                        lines_q[idx][hit_way].data  <= wdata_q;
                        lines_q[idx][hit_way].dirty <= 1'b1;
                        rdata_q                     <= wdata_q;
                    end else begin
                        rdata_q <= lines_q[idx][hit_way].data;
                    end
                end else begin
                    way_q <= victim_way;
                    hit_q <= 1'b0;
                end
            end
            // Install on fill; a write miss merges its own data instead of mem_rdata.
            if ((state_q == StFill) && mem_ack) begin
                for (int unsigned w = 0; w < WAYS; w++) begin
                    lines_q[idx][w].age <= age_new[w];
                end
                lines_q[idx][way_q].valid <= 1'b1;
                lines_q[idx][way_q].tag   <= tag;
                lines_q[idx][way_q].dirty <= wren_q;
                lines_q[idx][way_q].data  <= wren_q ? wdata_q : mem_rdata;
                rdata_q                   <= wren_q ? wdata_q : mem_rdata;
            end
        end
    end

`ifdef CACHE_STATS_EN
    logic [15:0] hit_cnt_q, miss_cnt_q, evict_cnt_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
            evict_cnt_q <= '0;
        end else begin
            if (state_q == StLookup) begin
                if (hit_any) hit_cnt_q  <= hit_cnt_q + 16'd1;
                else         miss_cnt_q <= miss_cnt_q + 16'd1;
            end
            if ((state_q == StEvict) && mem_ack) evict_cnt_q <= evict_cnt_q + 16'd1;
        end
    end

    assign hit_cnt   = hit_cnt_q;
    assign miss_cnt  = miss_cnt_q;
    assign evict_cnt = evict_cnt_q;
`endif

endmodule

// File: doc/cache_setassoc_wb.md
Name: cache_setassoc_wb

Overview:
- Parametrised N-way set-associative, write-back, write-allocate cache with true-LRU replacement.
- Sits between a simple CPU-side request port and a backing-memory port with a req/ack handshake.
- Successor to the fixed 4x4 cache. Adds:
  - configurable sets, ways and widths;
  - reset;
  - dirty-victim write-back;
  - miss fill from memory;
  - a ready/valid request interface.

Parameters:
ADDR_W, 5, CPU address width in bits
DATA_W, 3, data word width; one word per line
SETS, 4, number of sets; power of two, >=2
WAYS, 4, associativity; power of two, >=2

Ports:
clock  input  1  single clock; all state updates on rising edge
resetn  input  1  asynchronous active-low reset
req_valid  input  1  CPU request present
req_ready  output  1  cache can accept a request; high only in IDLE
address  input  ADDR_W  request address; index = address[IW-1:0] with IW=log2(SETS); tag = address[ADDR_W-1:IW] (TW bits)
wren  input  1  1 = write, 0 = read
write  input  DATA_W  write data
read  output  DATA_W  response data; valid while read_valid
read_valid  output  1  one-cycle response pulse
hit  output  1  qualifies read_valid: 1 = request hit, 0 = missed
mem_req  output  1  backing-memory request; held until mem_ack
mem_we  output  1  1 = write-back, 0 = fill read
mem_addr  output  ADDR_W  line address {tag, index}
mem_wdata  output  DATA_W  victim data during write-back
mem_rdata  input  DATA_W  fill data; sampled in the mem_ack cycle
mem_ack  input  1  completes the current mem_req

Behaviour:
- Line state: valid, dirty, tag[TW-1:0], data[DATA_W-1:0], age[log2(WAYS)-1:0].
- Reset (async, immediate on resetn low):
  - every valid and dirty bit = 0; age of way w = w;
  - state = IDLE;
  - outputs: req_ready = 1; read_valid, hit, mem_req and mem_we = 0; read, mem_addr and mem_wdata = 0.
  - Reset mid-transaction aborts it: mem_req drops immediately and no line is written.
- FSM states: IDLE, LOOKUP, EVICT, FILL, RESP.
- IDLE:
  - On req_valid && req_ready, latch address, wren and write, then go to LOOKUP.
  - Input changes after acceptance are ignored.
- LOOKUP: compare tag against all valid ways of the set.
  - Hit:
    - write hit: data = write, dirty = 1;
    - read hit: line unchanged;
    - go to RESP with hit = 1.
  - Miss, victim selection:
    - the lowest-index invalid way;
    - otherwise the way with age == WAYS-1.
  - Miss, next state: victim valid and dirty -> EVICT; otherwise -> FILL.
- EVICT:
  - mem_req = 1, mem_we = 1, mem_addr = {victim tag, index}, mem_wdata = victim data.
  - Outputs held stable until mem_ack; on mem_ack go to FILL.
- FILL:
  - mem_req = 1, mem_we = 0, mem_addr = {req tag, index}.
  - On mem_ack, install the line: valid = 1, tag = req tag.
    - write miss: data = write data, dirty = 1 (write-allocate merge);
    - read miss: data = mem_rdata, dirty = 0.
  - Go to RESP with hit = 0.
- mem_ack outside EVICT/FILL is ignored. mem_req deasserts in the cycle after mem_ack.
- RESP:
  - read_valid = 1 for exactly one cycle; read = the line's data after the update (write data on a write).
  - Then go to IDLE.
- Latency (acceptance edge to read_valid high): hit = 2 cycles; clean miss = 3 + fill wait; dirty miss adds the eviction wait.
- LRU update: applied at the LOOKUP hit or at FILL install, to the accessed way only.
  - Ways with age < old age of the accessed way increment; accessed way age = 0.
  - Ages within a set remain a permutation of 0..WAYS-1 at all times.

Optional Feature:
CACHE_STATS_EN
- Defined: adds output ports hit_cnt[15:0], miss_cnt[15:0] and evict_cnt[15:0].
  - hit_cnt and miss_cnt increment in LOOKUP; evict_cnt increments on the EVICT mem_ack.
  - All wrap modulo 2^16 and reset to 0.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Package cache_pkg holds:
  - the FSM state enum;
  - localparam derivations IW = $clog2(SETS), TW = ADDR_W-IW, AW = $clog2(WAYS);
  - the line struct typedef (valid, dirty, tag, data, age).
- One sub-module, cache_lru_ctrl: combinational age-vector update plus victim-way select for one set. The top instantiates it once on the indexed set.

Test Plan:
- Reset, then read address 5'b10101 (index 1, tag 3'b101), mem_rdata = 3'b011:
  - FILL mem_addr = 5'b10101, mem_we = 0;
  - read_valid with read = 3'b011, hit = 0;
  - repeat read -> hit = 1, read = 3'b011, 2-cycle latency, no mem_req.
- Write 3'b110 to 5'b00110 (miss), then read 5'b00110:
  - no memory read data used for the write;
  - read = 3'b110, hit = 1.
- Fill set 0 with tags 0..3 via writes (all dirty), then read tag 0 again, then access tag 4 in set 0:
  - victim is tag 1 (the LRU way);
  - EVICT first: mem_we = 1, mem_addr = 5'b00100, mem_wdata = tag-1 data;
  - then FILL.
- mem_ack delayed 5 cycles in EVICT: mem_req, mem_addr and mem_wdata stable for all 5 cycles; req_ready = 0 throughout.
- Assert resetn low during FILL:
  - mem_req = 0 immediately;
  - afterwards the same address misses (valid cleared); req_ready = 1.
- With CACHE_STATS_EN: 3 hits, 2 misses and 1 eviction -> hit_cnt = 3, miss_cnt = 2, evict_cnt = 1.
